// File: rtl/fft_pkg.sv
// Shared definitions for the 64-point radix-2 FFT control path.
package fft_pkg;

    localparam int FFT_N              = 64;
    localparam int FFT_LOG2N          = 6;
    localparam int FFT_BFLY_PER_STAGE = FFT_N / 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fft_state_e;

    // Output scaling strategy, latched once per transform.
    typedef enum logic {
        SCALE_PER_STAGE = 1'b0,  // shift by 1 after every stage
        SCALE_FINAL     = 1'b1   // single shift by log2(N) on the last stage
    } fft_scale_e;

    // Right-shift the datapath applies to butterflies of the given stage.
    function automatic logic [2:0] shift_for_stage(input fft_scale_e mode,
                                                   input logic [2:0] stage);
        logic [2:0] amt;
        amt = 3'd1;
        if (mode == SCALE_FINAL) begin
            amt = (stage == 3'(FFT_LOG2N - 1)) ? 3'(FFT_LOG2N) : 3'd0;
        end
        return amt;
    endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Combinational butterfly address / twiddle index generator for a
// decimation-in-frequency 64-point FFT: stage s pairs points that are
// span = 32>>s apart.
module fft_addr_gen
    import fft_pkg::*;
(
    input  logic [2:0] s,
    input  logic [4:0] b,
    output logic [5:0] Addr_A,
    output logic [5:0] Addr_B,
    output logic [4:0] Tw_Idx
);

    localparam logic [2:0] LAST_STAGE = 3'(FFT_LOG2N - 1);

    logic [5:0] span;
    logic [5:0] pos;
    logic [5:0] grp;
    logic [5:0] addr_a;
    logic [5:0] tw_full;

    // Split b into group and position inside the group, then rebuild addresses.
    always_comb begin
        span    = 6'(FFT_BFLY_PER_STAGE) >> s;
        pos     = {1'b0, b} & (span - 6'd1);
        grp     = {1'b0, b} >> (LAST_STAGE - s);
        addr_a  = ((grp * span) << 1) + pos;
        tw_full = pos << s;
        Addr_A  = addr_a;
        Addr_B  = addr_a + span;
        Tw_Idx  = tw_full[4:0];
    end

endmodule

// File: rtl/fft_stage_sequencer.sv
// Control sequencer for an in-place 64-point FFT: walks 6 stages of 32
// butterflies, waits PIPE_LAT cycles after each stage for the datapath to
// retire its results, then pulses Done. All outputs are registered, so a
// butterfly issued in a RUN cycle is presented on the outputs one cycle later.
module fft_stage_sequencer
    import fft_pkg::*;
#(
    parameter int PIPE_LAT = 3
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic       Start,
    input  logic       Abort,
    input  logic       Scale_Mode,
    input  logic       Stall,
    output logic       Busy,
    output logic       Done,
    output logic       Bfly_Valid,
    output logic [2:0] Stage,
    output logic [5:0] Addr_A,
    output logic [5:0] Addr_B,
    output logic [4:0] Tw_Idx,
    output logic [2:0] Shift_Amt
);

    localparam logic [2:0] LAST_STAGE = 3'(FFT_LOG2N - 1);
    localparam logic [4:0] LAST_BFLY  = 5'(FFT_BFLY_PER_STAGE - 1);
    localparam logic [2:0] LAST_DRAIN = 3'(PIPE_LAT - 1);

    fft_state_e state_q;
    fft_scale_e mode_q;
    logic [2:0] stage_q;
    logic [4:0] bfly_q;
    logic [2:0] drain_q;

    logic       busy_q;
    logic       done_q;
    logic       valid_q;
    logic [2:0] stage_out_q;
    logic [5:0] addr_a_q;
    logic [5:0] addr_b_q;
    logic [4:0] tw_q;
    logic [2:0] shift_q;

    logic [5:0] addr_a_d;
    logic [5:0] addr_b_d;
    logic [4:0] tw_d;

    fft_addr_gen u_addr_gen (
        .s      (stage_q),
        .b      (bfly_q),
        .Addr_A (addr_a_d),
        .Addr_B (addr_b_d),
        .Tw_Idx (tw_d)
    );

    // FSM, counters and registered outputs; Abort overrides everything.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= ST_IDLE;
            mode_q      <= SCALE_PER_STAGE;
            stage_q     <= 3'd0;
            bfly_q      <= 5'd0;
            drain_q     <= 3'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            valid_q     <= 1'b0;
            stage_out_q <= 3'd0;
            addr_a_q    <= 6'd0;
            addr_b_q    <= 6'd0;
            tw_q        <= 5'd0;
            shift_q     <= 3'd0;
        end else if (Abort) begin
            state_q <= ST_IDLE;
            stage_q <= 3'd0;
            bfly_q  <= 5'd0;
            drain_q <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    valid_q <= 1'b0;
                    done_q  <= 1'b0;
                    if (Start) begin
                        state_q <= ST_RUN;
                        mode_q  <= fft_scale_e'(Scale_Mode);
                        stage_q <= 3'd0;
                        bfly_q  <= 5'd0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (Stall) begin
                        valid_q <= 1'b0;
                    end else begin
                        valid_q     <= 1'b1;
                        stage_out_q <= stage_q;
                        addr_a_q    <= addr_a_d;
                        addr_b_q    <= addr_b_d;
                        tw_q        <= tw_d;
                        shift_q     <= shift_for_stage(mode_q, stage_q);
                        if (bfly_q == LAST_BFLY) begin
                            state_q <= ST_DRAIN;
                            drain_q <= 3'd0;
                        end else begin
                            bfly_q <= bfly_q + 5'd1;
                        end
                    end
                end
                ST_DRAIN: begin
                    valid_q <= 1'b0;
                    if (drain_q == LAST_DRAIN) begin
                        if (stage_q == LAST_STAGE) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                            stage_q <= stage_q + 3'd1;
                            bfly_q  <= 5'd0;
                        end
                    end else begin
                        drain_q <= drain_q + 3'd1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign Busy       = busy_q;
    assign Done       = done_q;
    assign Bfly_Valid = valid_q;
    assign Stage      = stage_out_q;
    assign Addr_A     = addr_a_q;
    assign Addr_B     = addr_b_q;
    assign Tw_Idx     = tw_q;
    assign Shift_Amt  = shift_q;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Testbench for fft_stage_sequencer: a work-queue model of the transform
// (32 issue slots + PIPE_LAT drain slots per stage) predicts issue cycles and
// completion time; butterfly addresses come from an independent pair search.
module tb_fft_stage_sequencer;

    localparam int L = 3;

    logic       Clock = 1'b0;
    logic       Reset_n = 1'b0;
    logic       Start = 1'b0;
    logic       Abort = 1'b0;
    logic       Scale_Mode = 1'b0;
    logic       Stall = 1'b0;
    logic       Busy, Done, Bfly_Valid;
    logic [2:0] Stage;
    logic [5:0] Addr_A, Addr_B;
    logic [4:0] Tw_Idx;
    logic [2:0] Shift_Amt;

    fft_stage_sequencer #(.PIPE_LAT(L)) dut (
        .Clock      (Clock),
        .Reset_n    (Reset_n),
        .Start      (Start),
        .Abort      (Abort),
        .Scale_Mode (Scale_Mode),
        .Stall      (Stall),
        .Busy       (Busy),
        .Done       (Done),
        .Bfly_Valid (Bfly_Valid),
        .Stage      (Stage),
        .Addr_A     (Addr_A),
        .Addr_B     (Addr_B),
        .Tw_Idx     (Tw_Idx),
        .Shift_Amt  (Shift_Amt)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        bit issue;
        int s;
        int b;
    } slot_t;

    typedef struct packed {
        int stg;
        int a;
        int bb;
        int tw;
        int sh;
    } beat_t;

    int n_cmp = 0;
    int n_bad = 0;

    slot_t    sched[$];
    beat_t    beats[$];
    int       done_cycle, done_pulses, stall_edges, frozen_viol, valid_err, busy_low;
    logic     busy_after_done;
    bit       aborted, rst_hit, rst_nonzero;
    logic [2:0] abort_state;

    // Reference butterfly: the b-th point (ascending) whose stage bit is clear
    // is the upper operand; its partner has that bit set.
    function automatic beat_t ref_beat(input int s, input int b, input bit mode);
        beat_t r;
        int half;
        int cnt;
        half = 32 >> s;
        cnt  = 0;
        r = '{stg: s, a: 0, bb: 0, tw: 0, sh: 0};
        for (int i = 0; i < 64; i++) begin
            if (((i / half) % 2) == 0) begin
                if (cnt == b) begin
                    r.a  = i;
                    r.bb = i + half;
                    r.tw = ((i % half) << s) % 32;
                end
                cnt++;
            end
        end
        r.sh = mode ? ((s == 5) ? 6 : 0) : 1;
        return r;
    endfunction

    // Drives one transform from Start and records what the DUT does.
    task automatic run_transform(input bit mode, input int stall_pct,
                                 input int st_s, input int st_b, input int st_len,
                                 input bit toggles, input bit start_in_done,
                                 input int abort_s, input int abort_b, input int rst_s);
        slot_t front;
        int    stall_left;
        bit    exp_valid;
        bit    ended;
        beat_t last;
        stall_left = st_len;
        sched.delete();
        beats.delete();
        for (int s = 0; s < 6; s++) begin
            for (int b = 0; b < 32; b++) sched.push_back('{1'b1, s, b});
            for (int k = 0; k < L; k++) sched.push_back('{1'b0, s, k});
        end
        done_cycle = -1; done_pulses = 0; stall_edges = 0; frozen_viol = 0;
        valid_err = 0; busy_low = 0; busy_after_done = 1'b1;
        aborted = 0; rst_hit = 0; rst_nonzero = 0; abort_state = 3'b111; ended = 0;
        Scale_Mode = mode;
        Start = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        if (!Busy) busy_low++;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            Stall = 1'b0;
            Abort = 1'b0;
            if (toggles) begin
                Scale_Mode = 1'($urandom);
                Start      = 1'($urandom);
            end
            if (sched.size() == 0) begin
                Start = start_in_done;
            end else begin
                front = sched[0];
                if (front.issue && front.s == st_s && front.b == st_b && stall_left > 0) begin
                    Stall = 1'b1;
                    stall_left--;
                end else if (stall_pct > 0 && int'($urandom_range(99)) < stall_pct) begin
                    Stall = 1'b1;
                end
                if (front.issue && front.s == abort_s && front.b == abort_b) Abort = 1'b1;
                if (!front.issue && front.s == rst_s) begin
                    Reset_n = 1'b0;
                    #1;
                    rst_hit = 1;
                    if ({Busy, Done, Bfly_Valid, Stage, Addr_A, Addr_B, Tw_Idx, Shift_Amt} !== '0)
                        rst_nonzero = 1;
                    Start = 1'b0; Stall = 1'b0; Scale_Mode = 1'b0;
                    return;
                end
            end
            @(posedge Clock); #1;
            if (Abort) begin
                Abort = 1'b0;
                aborted = 1;
                abort_state = {Busy, Done, Bfly_Valid};
                Start = 1'b0; Stall = 1'b0; Scale_Mode = 1'b0;
                return;
            end
            exp_valid = 0;
            if (sched.size() == 0) begin
                ended = 1;
            end else if (sched[0].issue && Stall) begin
                stall_edges++;
            end else begin
                exp_valid = sched[0].issue;
                front = sched.pop_front();
            end
            if (Bfly_Valid !== exp_valid) valid_err++;
            if (Bfly_Valid) begin
                beats.push_back('{int'(Stage), int'(Addr_A), int'(Addr_B), int'(Tw_Idx), int'(Shift_Amt)});
            end else if (beats.size() > 0) begin
                last = beats[beats.size() - 1];
                if (last != '{int'(Stage), int'(Addr_A), int'(Addr_B), int'(Tw_Idx), int'(Shift_Amt)})
                    frozen_viol++;
            end
            if (Done) begin
                done_pulses++;
                if (done_cycle < 0) done_cycle = cyc + 1;
            end
            if (ended) begin
                busy_after_done = Busy;
                break;
            end
            if (!Busy) busy_low++;
        end
        Start = 1'b0; Stall = 1'b0; Scale_Mode = 1'b0; Abort = 1'b0;
    endtask

    // Lets the DUT idle for n cycles, counting cycles with Busy or Done high.
    task automatic idle_watch(input int n, output int busy_hi, output int done_hi);
        busy_hi = 0;
        done_hi = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge Clock); #1;
            if (Busy !== 1'b0) busy_hi++;
            if (Done !== 1'b0) done_hi++;
        end
    endtask

    task automatic test_reset();
        int bh, dh;
        #2;
        n_cmp++;
        if ({Busy, Done, Bfly_Valid, Stage, Addr_A, Addr_B, Tw_Idx, Shift_Amt} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h required 0",
                     {Busy, Done, Bfly_Valid, Stage, Addr_A, Addr_B, Tw_Idx, Shift_Amt});
        end
        repeat (3) @(posedge Clock);
        #1 Reset_n = 1'b1;
        idle_watch(5, bh, dh);
        n_cmp++;
        if (bh + dh != 0) begin
            n_bad++;
            $display("FAIL reset_idle: busy/done cycles %0d required 0", bh + dh);
        end
        $display("test_reset: done");
    endtask

    task automatic test_full_run();
        beat_t e;
        run_transform(1'b0, 0, -1, -1, 0, 1'b0, 1'b0, -1, -1, -1);
        n_cmp++;
        if (beats.size() != 192) begin n_bad++; $display("FAIL full_pulses: got %0d required 192", beats.size()); end
        if (beats.size() == 192) begin
            n_cmp++;
            if (beats[0].a != 0 || beats[0].bb != 32 || beats[0].tw != 0) begin
                n_bad++; $display("FAIL full_b0: got A=%0d B=%0d Tw=%0d required 0/32/0", beats[0].a, beats[0].bb, beats[0].tw);
            end
            n_cmp++;
            if (beats[31].a != 31 || beats[31].bb != 63 || beats[31].tw != 31) begin
                n_bad++; $display("FAIL full_b31: got A=%0d B=%0d Tw=%0d required 31/63/31", beats[31].a, beats[31].bb, beats[31].tw);
            end
            for (int k = 0; k < 192; k++) begin
                e = ref_beat(k / 32, k % 32, 1'b0);
                n_cmp++;
                if (beats[k] != e) begin
                    n_bad++;
                    $display("FAIL full_seq[%0d]: got S=%0d A=%0d B=%0d Tw=%0d Sh=%0d required S=%0d A=%0d B=%0d Tw=%0d Sh=%0d",
                             k, beats[k].stg, beats[k].a, beats[k].bb, beats[k].tw, beats[k].sh, e.stg, e.a, e.bb, e.tw, e.sh);
                end
            end
        end
        n_cmp++;
        if (done_cycle != 6 * (32 + L)) begin n_bad++; $display("FAIL full_latency: got %0d required %0d", done_cycle, 6 * (32 + L)); end
        n_cmp++;
        if (done_pulses != 1) begin n_bad++; $display("FAIL full_done_pulses: got %0d required 1", done_pulses); end
        n_cmp++;
        if (busy_after_done !== 1'b0) begin n_bad++; $display("FAIL full_busy_after: got %b required 0", busy_after_done); end
        n_cmp++;
        if (valid_err + frozen_viol + busy_low != 0) begin
            n_bad++; $display("FAIL full_timing: valid_err=%0d frozen=%0d busy_low=%0d required 0", valid_err, frozen_viol, busy_low);
        end
        $display("test_full_run: pulses=%0d done_cycle=%0d", beats.size(), done_cycle);
    endtask

    task automatic test_addr_spot();
        beat_t e;
        run_transform(1'b0, 25, -1, -1, 0, 1'b1, 1'b0, -1, -1, -1);
        n_cmp++;
        if (beats.size() != 192) begin n_bad++; $display("FAIL spot_pulses: got %0d required 192", beats.size()); end
        if (beats.size() == 192) begin
            n_cmp++;
            if (beats[48].stg != 1 || beats[48].a != 32 || beats[48].bb != 48 || beats[48].tw != 0) begin
                n_bad++; $display("FAIL spot_s1b16: got A=%0d B=%0d Tw=%0d required 32/48/0", beats[48].a, beats[48].bb, beats[48].tw);
            end
            n_cmp++;
            if (beats[69].stg != 2 || beats[69].a != 5 || beats[69].bb != 13 || beats[69].tw != 20) begin
                n_bad++; $display("FAIL spot_s2b5: got A=%0d B=%0d Tw=%0d required 5/13/20", beats[69].a, beats[69].bb, beats[69].tw);
            end
            n_cmp++;
            if (beats[167].stg != 5 || beats[167].a != 14 || beats[167].bb != 15 || beats[167].tw != 0) begin
                n_bad++; $display("FAIL spot_s5b7: got A=%0d B=%0d Tw=%0d required 14/15/0", beats[167].a, beats[167].bb, beats[167].tw);
            end
            for (int k = 0; k < 192; k++) begin
                e = ref_beat(k / 32, k % 32, 1'b0);
                n_cmp++;
                if (beats[k] != e) begin
                    n_bad++; $display("FAIL spot_seq[%0d]: got A=%0d B=%0d Tw=%0d required A=%0d B=%0d Tw=%0d",
                                      k, beats[k].a, beats[k].bb, beats[k].tw, e.a, e.bb, e.tw);
                end
            end
        end
        n_cmp++;
        if (done_cycle != 6 * (32 + L) + stall_edges) begin
            n_bad++; $display("FAIL spot_latency: got %0d required %0d", done_cycle, 6 * (32 + L) + stall_edges);
        end
        n_cmp++;
        if (valid_err + frozen_viol != 0) begin
            n_bad++; $display("FAIL spot_stall_behaviour: valid_err=%0d frozen=%0d required 0", valid_err, frozen_viol);
        end
        $display("test_addr_spot: stalls=%0d done_cycle=%0d", stall_edges, done_cycle);
    endtask

    task automatic test_scale_mode();
        int bad_shift;
        run_transform(1'b1, 0, -1, -1, 0, 1'b1, 1'b0, -1, -1, -1);
        bad_shift = 0;
        foreach (beats[k]) begin
            if (beats[k].sh != ((k / 32 == 5) ? 6 : 0)) bad_shift++;
        end
        n_cmp++;
        if (beats.size() != 192 || bad_shift != 0) begin
            n_bad++; $display("FAIL scale_shift: pulses=%0d wrong_shifts=%0d required 192/0", beats.size(), bad_shift);
        end
        n_cmp++;
        if (done_cycle != 6 * (32 + L)) begin n_bad++; $display("FAIL scale_latency: got %0d required %0d", done_cycle, 6 * (32 + L)); end
        $display("test_scale_mode: pulses=%0d last_shift=%0d", beats.size(), (beats.size() > 0) ? beats[beats.size() - 1].sh : -1);
    endtask

    task automatic test_stall();
        run_transform(1'b0, 0, 3, 10, 5, 1'b0, 1'b0, -1, -1, -1);
        n_cmp++;
        if (stall_edges != 5 || done_cycle != 6 * (32 + L) + 5) begin
            n_bad++; $display("FAIL stall_latency: stalls=%0d done=%0d required 5/%0d", stall_edges, done_cycle, 6 * (32 + L) + 5);
        end
        n_cmp++;
        if (valid_err + frozen_viol != 0) begin
            n_bad++; $display("FAIL stall_freeze: valid_err=%0d frozen=%0d required 0", valid_err, frozen_viol);
        end
        n_cmp++;
        if (beats.size() != 192) begin
            n_bad++; $display("FAIL stall_pulses: got %0d required 192", beats.size());
        end else if (beats[106].stg != 3 || beats[106].a != 18 || beats[106].bb != 22 || beats[106].tw != 16) begin
            n_bad++; $display("FAIL stall_resume: got S=%0d A=%0d B=%0d Tw=%0d required 3/18/22/16",
                              beats[106].stg, beats[106].a, beats[106].bb, beats[106].tw);
        end
        $display("test_stall: stalls=%0d done_cycle=%0d", stall_edges, done_cycle);
    endtask

    task automatic test_abort_and_done_start();
        int ab, bh, dh;
        ab = int'($urandom_range(31));
        run_transform(1'b0, 0, -1, -1, 0, 1'b0, 1'b0, 2, ab, -1);
        n_cmp++;
        if (!aborted || abort_state !== 3'b000) begin
            n_bad++; $display("FAIL abort_state: busy/done/valid=%b required 000", abort_state);
        end
        n_cmp++;
        if (beats.size() != 64 + ab) begin n_bad++; $display("FAIL abort_pulses: got %0d required %0d", beats.size(), 64 + ab); end
        idle_watch(20, bh, dh);
        n_cmp++;
        if (bh + dh != 0) begin n_bad++; $display("FAIL abort_idle: busy/done cycles %0d required 0", bh + dh); end
        run_transform(1'b0, 0, -1, -1, 0, 1'b0, 1'b1, -1, -1, -1);
        n_cmp++;
        if (done_cycle != 6 * (32 + L) || busy_after_done !== 1'b0) begin
            n_bad++; $display("FAIL done_start_run: done=%0d busy_after=%b required %0d/0", done_cycle, busy_after_done, 6 * (32 + L));
        end
        idle_watch(20, bh, dh);
        n_cmp++;
        if (bh + dh != 0) begin n_bad++; $display("FAIL done_start_ignored: busy/done cycles %0d required 0", bh + dh); end
        $display("test_abort_and_done_start: abort_b=%0d", ab);
    endtask

    task automatic test_reset_mid_drain();
        int bh, dh;
        run_transform(1'b1, 10, -1, -1, 0, 1'b0, 1'b0, -1, -1, 4);
        n_cmp++;
        if (!rst_hit || rst_nonzero) begin n_bad++; $display("FAIL rst_outputs: hit=%0d nonzero=%0d required 1/0", rst_hit, rst_nonzero); end
        n_cmp++;
        if (beats.size() != 160) begin n_bad++; $display("FAIL rst_pulses: got %0d required 160", beats.size()); end
        repeat (2) @(posedge Clock);
        #1 Reset_n = 1'b1;
        idle_watch(20, bh, dh);
        n_cmp++;
        if (bh + dh != 0) begin n_bad++; $display("FAIL rst_no_resume: busy/done cycles %0d required 0", bh + dh); end
        $display("test_reset_mid_drain: pulses_before_reset=%0d", beats.size());
    endtask

    task automatic test_random();
        beat_t e;
        bit    m;
        int    pct, bad;
        for (int it = 0; it < 3; it++) begin
            m   = 1'($urandom);
            pct = int'($urandom_range(50));
            run_transform(m, pct, -1, -1, 0, 1'b1, 1'b0, -1, -1, -1);
            bad = 0;
            foreach (beats[k]) begin
                e = ref_beat(k / 32, k % 32, m);
                if (beats[k] != e) bad++;
            end
            n_cmp++;
            if (beats.size() != 192 || bad != 0) begin
                n_bad++; $display("FAIL random_seq[%0d]: pulses=%0d wrong=%0d required 192/0", it, beats.size(), bad);
            end
            n_cmp++;
            if (done_cycle != 6 * (32 + L) + stall_edges || done_pulses != 1 || valid_err + frozen_viol != 0) begin
                n_bad++; $display("FAIL random_timing[%0d]: done=%0d required %0d pulses=%0d valid_err=%0d frozen=%0d",
                                  it, done_cycle, 6 * (32 + L) + stall_edges, done_pulses, valid_err, frozen_viol);
            end
            $display("test_random[%0d]: mode=%0d stall_pct=%0d stalls=%0d done_cycle=%0d", it, m, pct, stall_edges, done_cycle);
        end
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_addr_spot();
        test_scale_mode();
        test_stall();
        test_abort_and_done_start();
        test_reset_mid_drain();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fft_stage_sequencer.md
FFT_STAGE_SEQUENCER -- requirements
Module: fft_stage_sequencer

Interface
REQ-001 SHALL have parameter PIPE_LAT, default 3: butterfly datapath latency in cycles, legal range 1..7.
REQ-002 SHALL have port Clock  input  1  single system clock, rising edge.
REQ-003 SHALL have port Reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port Start  input  1  request one 64-point transform; sampled only in IDLE.
REQ-005 SHALL have port Abort  input  1  terminate the current transform.
REQ-006 SHALL have port Scale_Mode  input  1  0 = shift by 1 every stage; 1 = single shift by 6 on the final stage.
REQ-007 SHALL have port Stall  input  1  datapath back-pressure; freezes issue.
REQ-008 SHALL have port Busy  output  1  high in any state other than IDLE.
REQ-009 SHALL have port Done  output  1  one-cycle pulse at transform completion.
REQ-010 SHALL have port Bfly_Valid  output  1  the butterfly command on Addr_A/Addr_B/Tw_Idx is valid this cycle.
REQ-011 SHALL have port Stage  output  3  current stage, 0..5.
REQ-012 SHALL have port Addr_A  output  6  upper butterfly operand address.
REQ-013 SHALL have port Addr_B  output  6  lower butterfly operand address.
REQ-014 SHALL have port Tw_Idx  output  5  twiddle ROM index.
REQ-015 SHALL have port Shift_Amt  output  3  arithmetic right-shift (sign-extending) that the datapath applies to this butterfly's outputs.

Function
REQ-016 SHALL implement the states IDLE, RUN, DRAIN and DONE, with internal counters stage s (0..5), butterfly b (0..31) and drain d (0..PIPE_LAT-1).
REQ-017 SHALL move IDLE->RUN on the edge at which Start=1, clearing s and b to 0 and latching Scale_Mode for the whole transform.
REQ-018 SHALL, in RUN with Stall=0, assert Bfly_Valid and increment b; with Stall=1, deassert Bfly_Valid and hold all counters and outputs.
REQ-019 SHALL move RUN->DRAIN after the unstalled issue at b=31, clearing d; DRAIN ignores Stall and lasts exactly PIPE_LAT cycles with Bfly_Valid=0.
REQ-020 SHALL, at the end of DRAIN, go to RUN with s+1 and b=0 if s<5, otherwise go to DONE.
REQ-021 SHALL hold DONE for exactly one cycle with Done=1 and then return to IDLE; a Start during DONE is ignored.
REQ-022 SHALL ignore Start in every state except IDLE.
REQ-023 SHALL, when Abort=1 in any state, return to IDLE on the next edge with no Done pulse; Abort has priority over Start, Stall and all transitions.
REQ-024 SHALL generate addresses as: span = 32>>s, pos = b mod span, grp = b div span, Addr_A = 2*span*grp + pos, Addr_B = Addr_A + span, Tw_Idx = (pos<<s) mod 32.
REQ-025 SHALL set Shift_Amt as follows: Scale_Mode=0 gives 1 every stage; Scale_Mode=1 gives 0 for s=0..4 and 6 for s=5.
REQ-026 SHALL hold Addr_A/Addr_B/Tw_Idx/Stage/Shift_Amt at their last values whenever Bfly_Valid=0.
REQ-027 SHALL, with no stalls, take exactly 6*(32+PIPE_LAT) cycles from the first RUN cycle to the DONE cycle (210 at PIPE_LAT=3).

Reset
REQ-028 SHALL, on Reset_n low, immediately force state IDLE, s=b=d=0, Busy=0, Done=0, Bfly_Valid=0, Stage=0, Addr_A=0, Addr_B=0, Tw_Idx=0, Shift_Amt=0 and latched mode=0.
REQ-029 SHALL, on reset asserted mid-transform, abandon that transform with no Done pulse and never resume it.
REQ-030 SHALL require a fresh Start after reset deasserts before any transform begins.

Structure
REQ-031 SHALL take the following from shared package fft_pkg: FFT_N=64, FFT_LOG2N=6, the state enumeration and the scale-mode encodings.
REQ-032 SHALL place the REQ-024 address arithmetic in one combinational sub-module, fft_addr_gen (inputs s and b; outputs Addr_A, Addr_B, Tw_Idx).
REQ-033 SHALL register all outputs; the FSM and counters stay in fft_stage_sequencer.

Verification
REQ-034 SHALL cover this scenario: Start, no stall, PIPE_LAT=3 -> stage 0 b=0 gives A=0, B=32, Tw=0; b=31 gives A=31, B=63, Tw=31; Done exactly 210 cycles after the first RUN cycle; 192 total Bfly_Valid pulses.
REQ-035 SHALL cover this scenario: address spot checks -> stage 1 b=16 gives A=32, B=48, Tw=0; stage 2 b=5 gives A=5, B=13, Tw=20; stage 5 b=7 gives A=14, B=15, Tw=0.
REQ-036 SHALL cover this scenario: Scale_Mode=1 latched at Start, then toggled mid-run -> Shift_Amt=0 for stages 0..4 and 6 for stage 5; the toggle has no effect.
REQ-037 SHALL cover this scenario: Stall=1 for 5 cycles at stage 3 b=10 -> Bfly_Valid=0 and outputs frozen; resume issues b=10 unchanged; Done delayed by exactly 5 cycles.
REQ-038 SHALL cover this scenario: Abort at stage 2, then a Start during DONE of a later run -> IDLE next cycle with no Done; the Start in DONE yields no new transform.
REQ-039 SHALL cover this scenario: Reset_n low during stage 4 DRAIN -> all outputs 0 immediately; no Done; Busy=0 until the next Start.
